// File: rtl/tt_um_serial_sub_if.sv
// Tiny Tapeout tile pin bundle for the serial subtractor.
// The master drives ena/ui_in/uio_in; the slave (the tile) drives the outputs.
interface tt_um_serial_sub_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/tt_um_serial_sub.sv
// Bit-serial A-B subtractor, LSB first; result valid the cycle after the WIDTH-th accepted bit.
// No backpressure: bits are taken whenever ena & bit_valid, stalls simply hold all state.
module tt_um_serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  tt_um_serial_sub_if.slave   io
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [3:0]       count_q, count_d;
  logic             br_q, br_d;
  logic             ovf_q, ovf_d;
  logic             last_d_q, last_d_d;

  logic a_bit, b_bit, bit_valid, start;
  logic accept, take, br_in, diff, last_bit;
  logic unused_in;

  assign a_bit     = io.ui_in[0];
  assign b_bit     = io.ui_in[1];
  assign bit_valid = io.ui_in[2];
  assign start     = io.ui_in[3];
  assign unused_in = ^{io.ui_in[7:4], io.uio_in};

  assign accept = io.ena & bit_valid;
  // A start bit always begins a fresh word, so the incoming borrow is forced to 0.
  assign br_in  = start ? 1'b0 : br_q;
  assign diff   = a_bit ^ b_bit ^ br_in;

  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    count_d  = count_q;
    br_d     = br_q;
    ovf_d    = ovf_q;
    last_d_d = last_d_q;
    take     = 1'b0;
    last_bit = 1'b0;

    unique case (state_q)
      IDLE:    take = accept & start;
      RUN:     take = accept;
      DONE:    take = accept & start;
      default: take = 1'b0;
    endcase

    if (take) begin
      if (start) begin
        res_d   = {diff, {(WIDTH-1){1'b0}}};
        count_d = 4'd1;
      end else begin
        res_d   = {diff, res_q[WIDTH-1:1]};
        count_d = count_q + 4'd1;
      end
      last_bit = (count_d == 4'(WIDTH));
      br_d     = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_in);
      last_d_d = diff;
      // Overflow only means something on the sign bit; earlier bits keep it clear.
      ovf_d    = last_bit & (a_bit ^ b_bit) & (a_bit ^ diff);
      state_d  = last_bit ? DONE : RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      res_q    <= '0;
      count_q  <= '0;
      br_q     <= 1'b0;
      ovf_q    <= 1'b0;
      last_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      count_q  <= count_d;
      br_q     <= br_d;
      ovf_q    <= ovf_d;
      last_d_q <= last_d_d;
    end
  end

  assign io.uo_out  = {count_q, ovf_q, (state_q == DONE), br_q, last_d_q};
  assign io.uio_out = 8'(res_q);
  assign io.uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_serial_sub.sv
// Bench for tt_um_serial_sub: random and directed words, scoreboard checked on result_valid.
module tb_tt_um_serial_sub;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tt_um_serial_sub_if io();

  tt_um_serial_sub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io.slave)
  );

  typedef struct {
    logic [7:0] res;
    logic       br;
    logic       ovf;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit a, input bit b, input bit v, input bit s);
    io.ui_in = {4'($urandom_range(0, 15)), s, v, b, a};
    io.uio_in = 8'($urandom);
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int   sa, sb, sd;
    sa = int'(a);
    sb = int'(b);
    if (sa > 127) sa -= 256;
    if (sb > 127) sb -= 256;
    sd = sa - sb;
    e.res = 8'((int'(a) - int'(b)) & 255);
    e.br  = (a < b);
    e.ovf = (sd < -128) || (sd > 127);
    return e;
  endfunction

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1), 1'b0, $urandom_range(0, 1));
      step();
    end
  endtask

  // Sends nbits of A-B; per-bit outputs checked against prefix arithmetic.
  task automatic send_word(input logic [7:0] a, input logic [7:0] b, input int nbits,
                           input bit stalls, input int ena_at);
    int diff;
    int m;
    if (nbits == W) sb_q.push_back(model(a, b));
    diff = int'(a) - int'(b);
    for (int i = 0; i < nbits; i++) begin
      if (stalls && i > 0) begin
        int k;
        k = $urandom_range(1, 3);
        for (int j = 0; j < k; j++) begin
          drive($urandom_range(0, 1), $urandom_range(0, 1), 1'b0, $urandom_range(0, 1));
          step();
          chk("count_stall", int'(io.uo_out[7:4]), i);
        end
      end
      if (i == ena_at) begin
        io.ena = 1'b0;
        for (int j = 0; j < 4; j++) begin
          drive($urandom_range(0, 1), $urandom_range(0, 1), 1'b1, $urandom_range(0, 1));
          step();
          chk("count_ena_low", int'(io.uo_out[7:4]), i);
        end
        io.ena = 1'b1;
      end
      drive(a[i], b[i], 1'b1, (i == 0));
      step();
      m = (1 << (i + 1)) - 1;
      chk("count", int'(io.uo_out[7:4]), i + 1);
      chk("diff_bit", int'(io.uo_out[0]), (diff >>> i) & 1);
      chk("run_borrow", int'(io.uo_out[1]), int'((int'(a) & m) < (int'(b) & m)));
    end
  endtask

  // Monitor: one scoreboard entry per rising result_valid.
  initial begin
    bit   prev_rv;
    exp_t e;
    prev_rv = 1'b0;
    forever begin
      @(negedge clk);
      if (io.uo_out[2] === 1'b1 && !prev_rv) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got 0x%0h, expected no result", io.uio_out);
        end else begin
          e = sb_q.pop_front();
          chk("result", int'(io.uio_out), int'(e.res));
          chk("final_borrow", int'(io.uo_out[1]), int'(e.br));
          chk("overflow", int'(io.uo_out[3]), int'(e.ovf));
          chk("final_count", int'(io.uo_out[7:4]), W);
        end
      end
      prev_rv = (io.uo_out[2] === 1'b1);
    end
  end

  initial begin
    logic [7:0] ra, rb;
    rst_n    = 1'b0;
    io.ena   = 1'b1;
    io.ui_in = 8'h00;
    io.uio_in = 8'h00;
    #12;
    chk("reset_uo_out", int'(io.uo_out), 0);
    chk("reset_uio_out", int'(io.uio_out), 0);
    chk("reset_uio_oe", int'(io.uio_oe), 8'hFF);
    @(negedge clk);
    rst_n = 1'b1;

    send_word(8'h35, 8'h12, W, 1'b0, -1);
    idle(2);
    send_word(8'h12, 8'h35, W, 1'b0, -1);
    idle(1);
    send_word(8'h80, 8'h01, W, 1'b0, -1);
    send_word(8'h00, 8'h00, W, 1'b0, -1);
    idle(2);
    chk("done_hold_valid", int'(io.uo_out[2]), 1);
    send_word(8'hA5, 8'h5A, W, 1'b1, 4);
    idle(1);

    send_word(8'h00, 8'hFF, 3, 1'b0, -1);
    send_word(8'h0F, 8'h01, W, 1'b0, -1);
    idle(1);

    send_word(8'h3C, 8'h07, 5, 1'b0, -1);
    rst_n = 1'b0;
    #2;
    chk("midreset_uo_out", int'(io.uo_out), 0);
    chk("midreset_uio_out", int'(io.uio_out), 0);
    chk("midreset_uio_oe", int'(io.uio_oe), 8'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1), 1'b1, 1'b0);
      step();
      chk("no_start_count", int'(io.uo_out[7:4]), 0);
      chk("no_start_uo_out", int'(io.uo_out), 0);
    end

    for (int n = 0; n < 20; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      send_word(ra, rb, W, bit'($urandom_range(0, 1)),
                ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, W - 1)) : -1);
      idle($urandom_range(0, 2));
    end

    idle(3);
    chk("scoreboard_drain", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tt_um_serial_sub.md
# tt_um_serial_sub

Bit-serial two's-complement subtractor (A − B), the inverse companion to the team's combinational half-adder tile. Operands stream in LSB first, one bit pair per accepted cycle. A single borrow flip-flop chains the bits, and a shift register assembles the WIDTH-bit difference. The block sits behind the standard Tiny Tapeout tile interface: control and data arrive on `ui_in`, status appears on `uo_out`, and the assembled result is driven on the bidirectional pins.

## Interface
- `WIDTH`, default 8: operand/result width in bits. Legal range is 2..8. The result is zero-extended onto `uio_out`.
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `ena` input 1: tile enable. When low, all state holds and inputs are ignored.
- `ui_in` input 8:
  - [0] `a` bit
  - [1] `b` bit
  - [2] `bit_valid`
  - [3] `start` (first bit/LSB of a new word)
  - [7:4] unused
- `uo_out` output 8:
  - [0] last difference bit
  - [1] running borrow
  - [2] `result_valid`
  - [3] signed overflow
  - [7:4] `count`, the number of bits accepted in the current word (0..WIDTH)
- `uio_in` input 8: unused.
- `uio_out` output 8: assembled result `{0, res[WIDTH-1:0]}`.
- `uio_oe` output 8: constant 8'hFF (all pins are outputs).

## Operation
- **Accept condition:** a bit is accepted on an edge only when `ena` = 1 and `bit_valid` = 1. `start` without `bit_valid` has no effect.
- **Per-bit arithmetic:**
  - `d = a ^ b ^ br`
  - `br_next = (~a & b) | (~(a ^ b) & br)`
  - `br` is taken as 0 for any bit accepted with `start` = 1.
- **Result assembly:** shift right, `res <= {d, res[WIDTH-1:1]}`. After WIDTH accepted bits, `res[0]` holds the first (LSB) difference bit.
- **Overflow:** computed on the WIDTH-th bit only, as `ovf = (a ^ b) & (a ^ d)`. It is cleared on `start`.
- **Final borrow:** 1 exactly when A < B unsigned.
- **State machine:** three states, IDLE, RUN and DONE.
  - **IDLE:** `start` & `bit_valid` → accept bit 0, `count` = 1, go to RUN. `bit_valid` without `start` is ignored.
  - **RUN:** `bit_valid` & !`start` → accept the bit and increment `count`. When `count` becomes WIDTH, go to DONE. `bit_valid` low → hold (stall); there is no timeout.
  - **RUN, restart:** `start` & `bit_valid` → abort the current word, clear `res`, treat this bit as bit 0 (`count` = 1), stay in RUN.
  - **DONE:**
    - `result_valid` = 1.
    - `res`, borrow and overflow are held until the next `start` & `bit_valid`, which moves to RUN with `count` = 1.
    - `bit_valid` without `start` is ignored.
- **`result_valid`:** high only in DONE. It drops on the same edge that accepts a new bit 0.
- **Reset:** asserting `rst_n` low at any time, including mid-word, immediately forces:
  - state IDLE, `res`, `count`, borrow, overflow and last-d all 0;
  - `uo_out` = 8'h00, `uio_out` = 8'h00;
  - `uio_oe` stays 8'hFF.
- **Unused inputs:** `ui_in[7:4]` and `uio_in` have no effect.

## Timing
- All outputs except `uio_oe` are registered.
- The difference bit and updated borrow of an accepted bit appear on `uo_out` the cycle after the accepting edge.
- **Latency:** `result_valid` and the final `uio_out` value are visible the cycle after the edge that accepts bit WIDTH-1. The minimum word time is WIDTH cycles with back-to-back `bit_valid`.
- A new word may start on the very cycle after DONE is entered. There is no dead cycle.
- `ena` low freezes state for any number of cycles. The word continues correctly when `ena` returns high.
- Reset release is synchronous to the next `clk` edge. The first accept is possible on the first edge after `rst_n` rises.

## Test plan
- **Basic subtract:** 0x35 − 0x12, 8 consecutive valid cycles, `start` on bit 0 → `uio_out` = 0x23, borrow 0, ovf 0, `result_valid` = 1 after the 8th edge, `count` = 8.
- **Negative result:** 0x12 − 0x35 → `uio_out` = 0xDD, borrow 1, ovf 0.
- **Signed overflow:** 0x80 − 0x01 → `uio_out` = 0x7F, borrow 0, ovf 1. Then 0x00 − 0x00 back-to-back with no idle cycle → 0x00, borrow 0, ovf 0.
- **Stalls and enable:** 0xA5 − 0x5A with `bit_valid` low for 1–3 random cycles between bits and `ena` low for 4 cycles mid-word → `uio_out` = 0x4B, borrow 0. `count` holds during stalls and while `ena` is low.
- **Restart:** `start` reasserted after 3 bits of a first word, then a full 0x0F − 0x01 → `uio_out` = 0x0E. The first word leaves no trace in the result, borrow or overflow.
- **Reset mid-operation:** `rst_n` pulsed low after 5 bits → `uo_out` = 0x00 and `uio_out` = 0x00 immediately. `bit_valid` without `start` is then ignored (`count` stays 0).
